// File: rtl/axi_read_burst_ctrl.sv
// rtl/axi_read_burst_ctrl.sv - AXI read burst issuer with outstanding-burst limit
module axi_read_burst_ctrl #(
    parameter int C_ADDR_WIDTH      = 64,
    parameter int C_XFER_WIDTH      = 32,
    parameter int C_BURST_LEN       = 64,
    parameter int C_BYTES_PER_BEAT  = 64,
    parameter int C_MAX_OUTSTANDING = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    ctrl_start,
    input  logic [C_ADDR_WIDTH-1:0] ctrl_addr,
    input  logic [C_XFER_WIDTH-1:0] ctrl_xfer_beats,
    output logic                    ctrl_busy,
    output logic                    ctrl_done,
    output logic                    m_axi_arvalid,
    input  logic                    m_axi_arready,
    output logic [C_ADDR_WIDTH-1:0] m_axi_araddr,
    output logic [7:0]              m_axi_arlen,
    input  logic                    m_axi_rvalid,
    input  logic                    m_axi_rready,
    input  logic                    m_axi_rlast,
    output logic [7:0]              outstanding
);

    localparam int BURST_BYTES = C_BURST_LEN * C_BYTES_PER_BEAT;
    localparam int ALIGN_BITS  = $clog2(BURST_BYTES);
    localparam logic [C_ADDR_WIDTH-1:0] ALIGN_MASK  = {C_ADDR_WIDTH{1'b1}} << ALIGN_BITS;
    localparam logic [C_ADDR_WIDTH-1:0] ADDR_STEP   = C_ADDR_WIDTH'(BURST_BYTES);
    localparam logic [C_XFER_WIDTH-1:0] BURST_BEATS = C_XFER_WIDTH'(C_BURST_LEN);
    localparam logic [7:0]              MAX_OUT     = 8'(C_MAX_OUTSTANDING);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t                  state;
    state_t                  state_next;
    logic [C_XFER_WIDTH-1:0] beats_left;
    logic [C_XFER_WIDTH-1:0] cur_beats;
    logic [C_XFER_WIDTH-1:0] beats_after;
    logic [C_ADDR_WIDTH-1:0] addr_q;
    logic [7:0]              arlen_q;
    logic [7:0]              out_cnt;
    logic                    ar_fire;
    logic                    rlast_fire;
    logic                    slot_free;

    // arlen for the burst that starts with b beats still unissued
    function automatic logic [7:0] len_of(input logic [C_XFER_WIDTH-1:0] b);
        if (b == '0) begin
            return 8'd0;
        end else if (b >= BURST_BEATS) begin
            return 8'(C_BURST_LEN - 1);
        end else begin
            return 8'(b - C_XFER_WIDTH'(1));
        end
    endfunction

    assign cur_beats   = (beats_left >= BURST_BEATS) ? BURST_BEATS : beats_left;
    assign beats_after = beats_left - cur_beats;
    // Limit decision uses the registered count, so a freed slot is usable next cycle
    assign slot_free   = (out_cnt < MAX_OUT);
    assign ar_fire     = m_axi_arvalid & m_axi_arready;
    // RLAST with nothing in flight is stray and must not underflow the counter
    assign rlast_fire  = m_axi_rvalid & m_axi_rready & m_axi_rlast & (out_cnt != 8'd0);

    assign m_axi_araddr = addr_q;
    assign m_axi_arlen  = arlen_q;
    assign outstanding  = out_cnt;

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and control outputs; arvalid depends only on registered state,
    // so it stays stable while waiting for arready
    always_comb begin
        state_next    = state;
        m_axi_arvalid = 1'b0;
        ctrl_busy     = (state != IDLE);
        ctrl_done     = 1'b0;
        case (state)
            IDLE: begin
                if (ctrl_start) begin
                    state_next = (ctrl_xfer_beats == '0) ? DONE : ISSUE;
                end
            end
            ISSUE: begin
                m_axi_arvalid = slot_free && (beats_left != '0);
                if (m_axi_arvalid && m_axi_arready && (beats_after == '0)) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (out_cnt == 8'd0) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                ctrl_done  = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Burst address/length/remaining-beat bookkeeping and outstanding counter
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            addr_q     <= '0;
            arlen_q    <= 8'd0;
            beats_left <= '0;
            out_cnt    <= 8'd0;
        end else begin
            if (state == IDLE && ctrl_start) begin
                addr_q     <= ctrl_addr & ALIGN_MASK;
                beats_left <= ctrl_xfer_beats;
                arlen_q    <= len_of(ctrl_xfer_beats);
            end else if (ar_fire) begin
                addr_q     <= addr_q + ADDR_STEP;
                beats_left <= beats_after;
                arlen_q    <= len_of(beats_after);
            end
            if (ar_fire && !rlast_fire) begin
                out_cnt <= out_cnt + 8'd1;
            end else if (rlast_fire && !ar_fire) begin
                out_cnt <= out_cnt - 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_axi_read_burst_ctrl.sv
// tb/tb_axi_read_burst_ctrl.sv - self-checking bench for axi_read_burst_ctrl
module tb_axi_read_burst_ctrl;

    localparam int BL = 64;
    localparam logic [63:0] BURST_BYTES = 64'h1000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ctrl_start = 1'b0;
    logic [63:0] ctrl_addr = '0;
    logic [31:0] ctrl_xfer_beats = '0;
    logic        ctrl_busy;
    logic        ctrl_done;
    logic        m_axi_arvalid;
    logic        m_axi_arready = 1'b0;
    logic [63:0] m_axi_araddr;
    logic [7:0]  m_axi_arlen;
    logic        m_axi_rvalid = 1'b0;
    logic        m_axi_rready = 1'b1;
    logic        m_axi_rlast = 1'b0;
    logic [7:0]  outstanding;

    axi_read_burst_ctrl #(
        .C_ADDR_WIDTH(64), .C_XFER_WIDTH(32), .C_BURST_LEN(BL),
        .C_BYTES_PER_BEAT(64), .C_MAX_OUTSTANDING(2)
    ) dut (
        .clk(clk), .rst_n(rst_n), .ctrl_start(ctrl_start), .ctrl_addr(ctrl_addr),
        .ctrl_xfer_beats(ctrl_xfer_beats), .ctrl_busy(ctrl_busy), .ctrl_done(ctrl_done),
        .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
        .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen),
        .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready),
        .m_axi_rlast(m_axi_rlast), .outstanding(outstanding)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] addr;
        logic [7:0]  len;
    } ar_t;

    typedef struct {
        logic [63:0] addr;
        logic [31:0] beats;
        int          ready_mode;
        int          exp_bursts;
    } vec_t;

    ar_t         exp_q[$];
    int          rdue[$];
    vec_t        vecs[6];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          ar_count = 0;
    int          done_count = 0;
    int          ready_mode = 0;
    bit          auto_r = 1'b0;
    bit          prev_pending = 1'b0;
    logic [63:0] prev_addr = '0;
    logic [7:0]  prev_len = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // reference model of the burst split
    task automatic push_expected(input logic [63:0] addr, input logic [31:0] beats);
        logic [63:0] a;
        logic [31:0] b;
        logic [31:0] n;
        a = addr & ~(BURST_BYTES - 64'd1);
        b = beats;
        while (b != 0) begin
            n = (b >= BL) ? BL : b;
            exp_q.push_back('{a, 8'(n - 1)});
            a = a + BURST_BYTES;
            b = b - n;
        end
    endtask

    // one clock: observe at negedge, then drive next inputs just after posedge
    task automatic tick();
        ar_t e;
        @(negedge clk);
        if (!rst_n) begin
            prev_pending = 1'b0;
        end else begin
            if (prev_pending) begin
                check("ar_stable_valid", 64'(m_axi_arvalid), 64'd1);
                check("ar_stable_addr", m_axi_araddr, prev_addr);
                check("ar_stable_len", 64'(m_axi_arlen), 64'(prev_len));
            end
            prev_pending = m_axi_arvalid && !m_axi_arready;
            prev_addr    = m_axi_araddr;
            prev_len     = m_axi_arlen;
            if (m_axi_arvalid && m_axi_arready) begin
                ar_count++;
                if (exp_q.size() == 0) begin
                    check("ar_unexpected", m_axi_araddr, 64'hDEAD);
                end else begin
                    e = exp_q.pop_front();
                    check("ar_addr", m_axi_araddr, e.addr);
                    check("ar_len", 64'(m_axi_arlen), 64'(e.len));
                end
                if (auto_r) rdue.push_back(cyc + 4);
            end
            if (ctrl_done) done_count++;
        end
        @(posedge clk);
        #1;
        cyc++;
        if (ready_mode == 1) m_axi_arready = 1'b1;
        else if (ready_mode == 2) m_axi_arready = 1'($urandom_range(0, 1));
        if (auto_r) begin
            m_axi_rvalid = 1'b0;
            m_axi_rlast  = 1'b0;
            if (rdue.size() > 0 && rdue[0] <= cyc) begin
                void'(rdue.pop_front());
                m_axi_rvalid = 1'b1;
                m_axi_rlast  = 1'b1;
            end
        end
    endtask

    task automatic run_transfer(input string name, input logic [63:0] addr,
                                input logic [31:0] beats, input int rmode, input int exp_bursts);
        int ar0;
        int d0;
        int n;
        ar0 = ar_count;
        d0  = done_count;
        auto_r = 1'b1;
        ready_mode = rmode;
        rdue.delete();
        push_expected(addr, beats);
        ctrl_addr = addr;
        ctrl_xfer_beats = beats;
        ctrl_start = 1'b1;
        tick();
        ctrl_start = 1'b0;
        n = 0;
        while (done_count == d0 && n < 3000) begin
            tick();
            n++;
        end
        check({name, " done_seen"}, 64'(done_count != d0), 64'd1);
        check({name, " busy_after"}, 64'(ctrl_busy), 64'd0);
        check({name, " outstanding_after"}, 64'(outstanding), 64'd0);
        check({name, " ar_count"}, 64'(ar_count - ar0), 64'(exp_bursts));
        check({name, " sb_empty"}, 64'(exp_q.size()), 64'd0);
        tick();
        tick();
        check({name, " one_done"}, 64'(done_count - d0), 64'd1);
        auto_r = 1'b0;
        m_axi_rvalid = 1'b0;
        m_axi_rlast = 1'b0;
    endtask

    initial begin
        int ar0;
        int d0;
        int n;

        vecs[0] = '{64'h1000, 32'd200, 1, 4};
        vecs[1] = '{64'h1234, 32'd64, 1, 1};
        vecs[2] = '{64'h5000, 32'd1, 2, 1};
        vecs[3] = '{64'hFFFF_FFFF_FFFF_F000, 32'd128, 1, 2};
        vecs[4] = '{64'h0, 32'd65, 2, 2};
        vecs[5] = '{64'h20FFF, 32'd300, 2, 5};

        // reset state
        rst_n = 1'b0;
        tick();
        tick();
        check("rst_arvalid", 64'(m_axi_arvalid), 64'd0);
        check("rst_busy", 64'(ctrl_busy), 64'd0);
        check("rst_done", 64'(ctrl_done), 64'd0);
        check("rst_outstanding", 64'(outstanding), 64'd0);
        check("rst_araddr", m_axi_araddr, 64'd0);
        check("rst_arlen", 64'(m_axi_arlen), 64'd0);
        rst_n = 1'b1;
        tick();

        // table-driven full transfers
        for (int i = 0; i < 6; i++) begin
            run_transfer($sformatf("vec%0d", i), vecs[i].addr, vecs[i].beats,
                         vecs[i].ready_mode, vecs[i].exp_bursts);
        end

        // zero-beat transfer: done in the cycle after start, busy for one cycle
        ready_mode = 1;
        ar0 = ar_count;
        ctrl_addr = 64'h3000;
        ctrl_xfer_beats = 32'd0;
        ctrl_start = 1'b1;
        tick();
        ctrl_start = 1'b0;
        check("zero_done", 64'(ctrl_done), 64'd1);
        check("zero_busy", 64'(ctrl_busy), 64'd1);
        check("zero_arvalid", 64'(m_axi_arvalid), 64'd0);
        tick();
        check("zero_done_clear", 64'(ctrl_done), 64'd0);
        check("zero_busy_clear", 64'(ctrl_busy), 64'd0);
        check("zero_no_ar", 64'(ar_count - ar0), 64'd0);

        // arready held low: AR stays stable, second start ignored
        ready_mode = 0;
        m_axi_arready = 1'b0;
        auto_r = 1'b1;
        rdue.delete();
        ar0 = ar_count;
        d0 = done_count;
        push_expected(64'h8000, 32'd128);
        ctrl_addr = 64'h8000;
        ctrl_xfer_beats = 32'd128;
        ctrl_start = 1'b1;
        tick();
        ctrl_start = 1'b0;
        for (int k = 0; k < 5; k++) begin
            check("hold_arvalid", 64'(m_axi_arvalid), 64'd1);
            check("hold_araddr", m_axi_araddr, 64'h8000);
            check("hold_arlen", 64'(m_axi_arlen), 64'd63);
            ctrl_start = (k == 2);
            ctrl_addr = (k == 2) ? 64'h9000 : 64'h8000;
            ctrl_xfer_beats = (k == 2) ? 32'd1 : 32'd128;
            tick();
        end
        ctrl_start = 1'b0;
        ready_mode = 1;
        n = 0;
        while (done_count == d0 && n < 500) begin
            tick();
            n++;
        end
        check("hold_done_seen", 64'(done_count - d0), 64'd1);
        check("hold_ar_count", 64'(ar_count - ar0), 64'd2);
        check("hold_sb_empty", 64'(exp_q.size()), 64'd0);
        auto_r = 1'b0;
        m_axi_rvalid = 1'b0;
        m_axi_rlast = 1'b0;
        tick();

        // outstanding limit of 2, slot freed by one RLAST
        ready_mode = 1;
        ar0 = ar_count;
        d0 = done_count;
        push_expected(64'h0, 32'd256);
        ctrl_addr = 64'h0;
        ctrl_xfer_beats = 32'd256;
        ctrl_start = 1'b1;
        tick();
        ctrl_start = 1'b0;
        n = 0;
        while (ar_count - ar0 < 2 && n < 50) begin
            tick();
            n++;
        end
        tick();
        tick();
        tick();
        check("limit_ar_count", 64'(ar_count - ar0), 64'd2);
        check("limit_arvalid", 64'(m_axi_arvalid), 64'd0);
        check("limit_outstanding", 64'(outstanding), 64'd2);
        m_axi_rvalid = 1'b1;
        m_axi_rlast = 1'b1;
        tick();
        m_axi_rvalid = 1'b0;
        m_axi_rlast = 1'b0;
        check("limit_freed_arvalid", 64'(m_axi_arvalid), 64'd1);
        check("limit_freed_outstanding", 64'(outstanding), 64'd1);
        tick();
        check("limit_third_ar", 64'(ar_count - ar0), 64'd3);
        n = 0;
        while (done_count == d0 && n < 100) begin
            m_axi_rvalid = (outstanding != 8'd0);
            m_axi_rlast = (outstanding != 8'd0);
            tick();
            n++;
        end
        m_axi_rvalid = 1'b0;
        m_axi_rlast = 1'b0;
        check("limit_done_seen", 64'(done_count - d0), 64'd1);
        check("limit_total_ar", 64'(ar_count - ar0), 64'd4);
        tick();

        // AR handshake and RLAST together with outstanding=1
        ready_mode = 0;
        m_axi_arready = 1'b0;
        d0 = done_count;
        push_expected(64'hA000, 32'd128);
        ctrl_addr = 64'hA000;
        ctrl_xfer_beats = 32'd128;
        ctrl_start = 1'b1;
        tick();
        ctrl_start = 1'b0;
        m_axi_arready = 1'b1;
        tick();
        check("same_pre_outstanding", 64'(outstanding), 64'd1);
        m_axi_rvalid = 1'b1;
        m_axi_rlast = 1'b1;
        tick();
        check("same_outstanding", 64'(outstanding), 64'd1);
        check("same_arvalid_after", 64'(m_axi_arvalid), 64'd0);
        tick();
        m_axi_rvalid = 1'b0;
        m_axi_rlast = 1'b0;
        check("same_drained", 64'(outstanding), 64'd0);
        n = 0;
        while (done_count == d0 && n < 20) begin
            tick();
            n++;
        end
        check("same_done_seen", 64'(done_count - d0), 64'd1);
        check("same_sb_empty", 64'(exp_q.size()), 64'd0);
        tick();

        // reset mid-transfer after 2 of 4 ARs
        ready_mode = 1;
        ar0 = ar_count;
        d0 = done_count;
        push_expected(64'h40000, 32'd256);
        ctrl_addr = 64'h40000;
        ctrl_xfer_beats = 32'd256;
        ctrl_start = 1'b1;
        tick();
        ctrl_start = 1'b0;
        n = 0;
        while (ar_count - ar0 < 2 && n < 50) begin
            tick();
            n++;
        end
        check("abort_two_ars", 64'(ar_count - ar0), 64'd2);
        exp_q.delete();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("abort_arvalid", 64'(m_axi_arvalid), 64'd0);
        check("abort_outstanding", 64'(outstanding), 64'd0);
        check("abort_busy", 64'(ctrl_busy), 64'd0);
        m_axi_rvalid = 1'b1;
        m_axi_rlast = 1'b1;
        tick();
        m_axi_rvalid = 1'b0;
        m_axi_rlast = 1'b0;
        check("abort_stray_rlast", 64'(outstanding), 64'd0);
        tick();
        tick();
        tick();
        check("abort_no_done", 64'(done_count - d0), 64'd0);
        check("abort_no_more_ar", 64'(ar_count - ar0), 64'd2);
        run_transfer("after_abort", 64'h1000, 32'd200, 1, 4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
